gpio_cfg_loader: RTL and testbench

Serial configuration master that sits directly upstream of the bottom GPIO pad bank and drives its daisy-chained `serial_clock` / `serial_data` / `serial_load` inputs. It holds one configuration word per pad in a local register file, written by the SoC over a simple register port. On request, or once automatically after reset, it shifts the whole chain out MSB-first and then pulses `serial_load` so every pad control block latches its word simultaneously.

---
 rtl/gpio_cfg_loader.sv | 200 ++++++++++++++++++++
 tb/tb_gpio_cfg_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_cfg_loader.sv
// gpio_cfg_loader
// Serial configuration master for the GPIO pad bank daisy chain. It keeps one
// control word per pad and, on request or once after reset, shifts the whole
// chain out MSB-first. A serial_load strobe then latches every pad at once.

module gpio_cfg_loader #(
  parameter int                       OPENFRAME_IO_PADS = 6,
  parameter int                       PAD_CTRL_BITS     = 12,
  parameter logic [PAD_CTRL_BITS-1:0] GPIO_DEFAULTS     = 12'hC00,
  parameter int                       CLK_DIV           = 2,
  parameter bit                       AUTO_LOAD         = 1'b1
) (
  input  logic                                 mclk,
  input  logic                                 resetn,
  input  logic                                 cfg_we,
  input  logic [$clog2(OPENFRAME_IO_PADS)-1:0] cfg_addr,
  input  logic [PAD_CTRL_BITS-1:0]             cfg_wdata,
  output logic [PAD_CTRL_BITS-1:0]             cfg_rdata,
  input  logic                                 xfer_start,
  output logic                                 xfer_busy,
  output logic                                 xfer_done,
  output logic                                 serial_clock_out,
  output logic                                 serial_data_out,
  output logic                                 serial_load_out
);

  localparam int N   = OPENFRAME_IO_PADS * PAD_CTRL_BITS;
  localparam int AW  = $clog2(OPENFRAME_IO_PADS);
  localparam int BCW = $clog2(N + 1);
  localparam int DCW = $clog2(CLK_DIV + 1);

  // Terminal counts: the bit counter exits on its last bit, the divider on its
  // last cycle of a phase, so neither ever wraps.
  localparam logic [BCW-1:0] LAST_BIT = BCW'(N - 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
  localparam logic [DCW-1:0] DIV_ONE  = DCW'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LOAD     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  logic [PAD_CTRL_BITS-1:0] cfg_mem_r [OPENFRAME_IO_PADS];
  logic [N-1:0]             snap_s;
  logic [PAD_CTRL_BITS-1:0] rdata_s;

  state_t                   state_r;
  logic [N-1:0]             shift_r;
  logic [BCW-1:0]           bit_cnt_r;
  logic [DCW-1:0]           div_cnt_r;
  logic                     auto_pend_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     sclk_r;
  logic                     sdata_r;
  logic                     sload_r;

  // Register file: in-range writes land on the next edge in every FSM state;
  // addresses past the last pad match no entry and are dropped.
  always_ff @(posedge mclk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < OPENFRAME_IO_PADS; i++) begin
        cfg_mem_r[i] <= GPIO_DEFAULTS;
      end
    end else begin
      for (int i = 0; i < OPENFRAME_IO_PADS; i++) begin
        if (cfg_we && (cfg_addr == AW'(i))) begin
          cfg_mem_r[i] <= cfg_wdata;
        end else begin
          cfg_mem_r[i] <= cfg_mem_r[i];
        end
      end
    end
  end

  // Combinational read port; an out-of-range address matches nothing and reads 0.
  always_comb begin
    rdata_s = '0;
    for (int i = 0; i < OPENFRAME_IO_PADS; i++) begin
      rdata_s = (cfg_addr == AW'(i)) ? cfg_mem_r[i] : rdata_s;
    end
  end

  // Pack the chain image with the highest pad on top so it leaves first.
  always_comb begin
    snap_s = '0;
    for (int i = 0; i < OPENFRAME_IO_PADS; i++) begin
      snap_s[i*PAD_CTRL_BITS +: PAD_CTRL_BITS] = cfg_mem_r[i];
    end
  end

  // Transfer sequencer: every serial output and status flag is a flop that is
  // updated alongside the state, so the pad chain never sees a glitch.
  always_ff @(posedge mclk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      shift_r     <= '0;
      bit_cnt_r   <= '0;
      div_cnt_r   <= '0;
      auto_pend_r <= AUTO_LOAD;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sclk_r      <= 1'b0;
      sdata_r     <= 1'b0;
      sload_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          sclk_r  <= 1'b0;
          sload_r <= 1'b0;
          done_r  <= 1'b0;
          // A start request and a pending auto-start merge into one transfer.
          if (xfer_start || auto_pend_r) begin
            state_r     <= ST_SHIFT_LO;
            shift_r     <= snap_s;
            bit_cnt_r   <= '0;
            div_cnt_r   <= '0;
            auto_pend_r <= 1'b0;
            busy_r      <= 1'b1;
            sdata_r     <= snap_s[N-1];
          end else begin
            busy_r  <= 1'b0;
            sdata_r <= 1'b0;
          end
        end

        ST_SHIFT_LO: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            sclk_r    <= 1'b1;
            state_r   <= ST_SHIFT_HI;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end

        ST_SHIFT_HI: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            sclk_r    <= 1'b0;
            shift_r   <= shift_r << 1;
            bit_cnt_r <= bit_cnt_r + BIT_ONE;
            // The counter still holds the index of the bit just clocked out.
            if (bit_cnt_r == LAST_BIT) begin
              sload_r <= 1'b1;
              sdata_r <= 1'b0;
              state_r <= ST_LOAD;
            end else begin
              // Next bit changes together with the falling clock edge.
              sdata_r <= shift_r[N-2];
              state_r <= ST_SHIFT_LO;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end

        ST_LOAD: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            sload_r   <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end

        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          state_r   <= ST_IDLE;
          div_cnt_r <= '0;
          bit_cnt_r <= '0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          sclk_r    <= 1'b0;
          sdata_r   <= 1'b0;
          sload_r   <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_rdata        = rdata_s;
  assign xfer_busy        = busy_r;
  assign xfer_done        = done_r;
  assign serial_clock_out = sclk_r;
  assign serial_data_out  = sdata_r;
  assign serial_load_out  = sload_r;

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Directed bench for gpio_cfg_loader: one instance with default parameters and
// one with CLK_DIV=1. A small downstream chain model captures the bit stream.

module tb_gpio_cfg_loader;

  logic        mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Instance A: defaults (CLK_DIV=2, AUTO_LOAD=1)
  logic        resetn, cfg_we, xfer_start;
  logic [2:0]  cfg_addr;
  logic [11:0] cfg_wdata, cfg_rdata;
  logic        xfer_busy, xfer_done, sclk, sdata, sload;

  // Instance B: CLK_DIV=1
  logic        resetn_b, cfg_we_b, xfer_start_b;
  logic [2:0]  cfg_addr_b;
  logic [11:0] cfg_wdata_b, cfg_rdata_b;
  logic        xfer_busy_b, xfer_done_b, sclk_b, sdata_b, sload_b;

  gpio_cfg_loader u_dut (
    .mclk(mclk), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .xfer_start(xfer_start),
    .xfer_busy(xfer_busy), .xfer_done(xfer_done), .serial_clock_out(sclk),
    .serial_data_out(sdata), .serial_load_out(sload)
  );

  gpio_cfg_loader #(.CLK_DIV(1)) u_dut_b (
    .mclk(mclk), .resetn(resetn_b), .cfg_we(cfg_we_b), .cfg_addr(cfg_addr_b),
    .cfg_wdata(cfg_wdata_b), .cfg_rdata(cfg_rdata_b), .xfer_start(xfer_start_b),
    .xfer_busy(xfer_busy_b), .xfer_done(xfer_done_b), .serial_clock_out(sclk_b),
    .serial_data_out(sdata_b), .serial_load_out(sload_b)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream chain model: shift on serial clock rise, latch on load rise.
  logic [71:0] chain_r = '0;
  logic [71:0] pads_r  = '0;
  int edges_a = 0, loads_a = 0, load_cyc_a = 0, dones_a = 0, edges_b = 0;

  always @(posedge sclk) begin
    chain_r <= {chain_r[70:0], sdata};
    edges_a <= edges_a + 1;
  end

  always @(posedge sload) begin
    pads_r  <= chain_r;
    loads_a <= loads_a + 1;
  end

  always @(negedge mclk) begin
    if (sload) load_cyc_a <= load_cyc_a + 1;
    if (xfer_done) dones_a <= dones_a + 1;
  end

  always @(posedge sclk_b) edges_b <= edges_b + 1;

  task automatic start_a();
    @(negedge mclk);
    xfer_start = 1'b1;
    @(posedge mclk);
    #1;
    xfer_start = 1'b0;
  endtask

  task automatic write_a(input logic [2:0] a, input logic [11:0] d);
    @(negedge mclk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge mclk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic write_b(input logic [2:0] a, input logic [11:0] d);
    @(negedge mclk);
    cfg_we_b = 1'b1; cfg_addr_b = a; cfg_wdata_b = d;
    @(posedge mclk);
    #1;
    cfg_we_b = 1'b0;
  endtask

  // Counts edges after the start edge until xfer_done is seen (bounded).
  task automatic wait_done_a(output int n);
    n = 0;
    while (n < 2000) begin
      @(posedge mclk);
      n++;
      #1;
      if (xfer_done) break;
    end
  endtask

  logic [71:0] exp_def, exp_s3, exp_s4;
  int n, e0, l0, lc0, d0, k;

  initial begin
    exp_def = {6{12'hC00}};
    exp_s3  = {12'h800, 12'hC00, 12'hC00, 12'hC00, 12'hC00, 12'h001};
    exp_s4  = {12'h800, 12'hC00, 12'hC00, 12'hABC, 12'hC00, 12'h001};

    resetn = 1'b0; cfg_we = 1'b0; xfer_start = 1'b0; cfg_addr = 3'd0; cfg_wdata = 12'h000;
    resetn_b = 1'b0; cfg_we_b = 1'b0; xfer_start_b = 1'b0; cfg_addr_b = 3'd0; cfg_wdata_b = 12'h000;

    // Reset state
    #12;
    check("reset_outputs", {sclk, sdata, sload, xfer_busy, xfer_done}, 5'b00000);
    check("reset_rdata0", cfg_rdata, 12'hC00);
    cfg_addr = 3'd5; #1;
    check("reset_rdata5", cfg_rdata, 12'hC00);

    // Auto-load after reset, with a coinciding xfer_start
    e0 = edges_a; l0 = loads_a; lc0 = load_cyc_a; d0 = dones_a;
    @(negedge mclk);
    resetn = 1'b1; xfer_start = 1'b1;
    @(posedge mclk); #1;
    xfer_start = 1'b0;
    check("auto_busy_edge0", xfer_busy, 1'b1);
    check("auto_first_bit", {sclk, sdata}, 2'b01);
    wait_done_a(n);
    check("auto_done_cycle", n, 290);
    check("auto_edges", edges_a - e0, 72);
    check("auto_stream", chain_r, exp_def);
    check("auto_load_pulses", loads_a - l0, 1);
    check("auto_load_cycles", load_cyc_a - lc0, 2);
    @(posedge mclk); #1;
    check("auto_busy_done_fall", {xfer_busy, xfer_done}, 2'b00);
    repeat (20) @(posedge mclk);
    #1;
    check("auto_single_xfer", dones_a - d0, 1);
    check("auto_idle_after", xfer_busy, 1'b0);

    // Written words, busy start pulses ignored
    write_a(3'd0, 12'h001);
    write_a(3'd5, 12'h800);
    d0 = dones_a;
    start_a();
    repeat (10) @(posedge mclk);
    @(negedge mclk); xfer_start = 1'b1;
    @(negedge mclk); xfer_start = 1'b0;
    repeat (100) @(posedge mclk);
    @(negedge mclk); xfer_start = 1'b1;
    @(negedge mclk); xfer_start = 1'b0;
    wait_done_a(n);
    check("s3_no_timeout", (n < 2000), 1'b1);
    check("s3_stream", chain_r, exp_s3);
    check("s3_first_bit", chain_r[71], 1'b1);
    check("s3_next_zeros", chain_r[70:60], 11'h000);
    check("s3_last_bit", chain_r[0], 1'b1);
    check("s3_pad0", pads_r[11:0], 12'h001);
    check("s3_pad5", pads_r[71:60], 12'h800);
    repeat (20) @(posedge mclk);
    #1;
    check("s3_one_done", dones_a - d0, 1);

    // Write pad2 while busy, then back-to-back transfer
    start_a();
    repeat (5) @(posedge mclk);
    write_a(3'd2, 12'hABC);
    check("s4_rdata_new", cfg_rdata, 12'hABC);
    check("s4_busy_during_write", xfer_busy, 1'b1);
    wait_done_a(n);
    check("s4_stream_old", chain_r, exp_s3);
    @(posedge mclk); #1;
    check("s4_idle_after_done", xfer_busy, 1'b0);
    start_a();
    check("s4_back_to_back", xfer_busy, 1'b1);
    wait_done_a(n);
    check("s4_b2b_done_cycle", n, 290);
    check("s4_stream_new", chain_r, exp_s4);

    // Reset in the middle of the chain (bit 30)
    repeat (3) @(posedge mclk);
    l0 = loads_a; e0 = edges_a;
    start_a();
    k = 0;
    while ((edges_a - e0) < 30 && k < 1000) begin
      @(posedge mclk);
      k++;
    end
    check("s5_reach_bit30", edges_a - e0, 30);
    @(negedge mclk); #2;
    check("s5_busy_before_rst", xfer_busy, 1'b1);
    resetn = 1'b0;
    #1;
    check("s5_async_outputs", {sclk, sdata, sload, xfer_busy, xfer_done}, 5'b00000);
    check("s5_regs_reset", cfg_rdata, 12'hC00);
    repeat (10) @(negedge mclk);
    check("s5_no_partial_load", loads_a - l0, 0);
    @(negedge mclk);
    resetn = 1'b1;
    e0 = edges_a;
    @(posedge mclk); #1;
    check("s5_auto_busy", xfer_busy, 1'b1);
    wait_done_a(n);
    check("s5_auto_done_cycle", n, 290);
    check("s5_auto_edges", edges_a - e0, 72);
    check("s5_auto_stream", chain_r, exp_def);
    check("s5_one_load", loads_a - l0, 1);

    // CLK_DIV=1 instance
    check("b_reset_rdata", cfg_rdata_b, 12'hC00);
    @(negedge mclk);
    resetn_b = 1'b1;
    e0 = edges_b;
    @(posedge mclk); #1;
    check("b_edge0", {xfer_busy_b, sclk_b}, 2'b10);
    @(posedge mclk); #1;
    check("b_clk_high_edge1", sclk_b, 1'b1);
    @(posedge mclk); #1;
    check("b_clk_low_edge2", sclk_b, 1'b0);
    n = 2;
    while (n < 1000) begin
      @(posedge mclk);
      n++;
      #1;
      if (xfer_done_b) break;
    end
    check("b_done_cycle", n, 145);
    check("b_edges", edges_b - e0, 72);
    write_b(3'd7, 12'hFFF);
    cfg_addr_b = 3'd7; #1;
    check("b_rdata_oob", cfg_rdata_b, 12'h000);
    for (int i = 0; i < 6; i++) begin
      cfg_addr_b = 3'(i); #1;
      check("b_rdata_untouched", cfg_rdata_b, 12'hC00);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
